// File: rtl/omem_readback_dma_pkg.sv
//------------------------------------------------------------------------------
// omem_readback_dma_pkg
//   Shared definitions for the OMEM readback DMA: default bus and bank sizing
//   and the sweep state machine encoding.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package omem_readback_dma_pkg;

  localparam int RB_WB_WIDTH      = 32;  // data/address width
  localparam int RB_MAX_CORES     = 4;   // OMEM banks present in the GPU top
  localparam int RB_MAX_CORE_BITS = 2;   // bank select width
  localparam int RB_FIFO_DEPTH    = 4;   // read-data buffer entries

  typedef enum logic [1:0] {
    RB_IDLE   = 2'd0,
    RB_SWEEP  = 2'd1,
    RB_DRAIN  = 2'd2,
    RB_FINISH = 2'd3
  } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/omem_readback_dma_fifo.sv
//------------------------------------------------------------------------------
// omem_rb_fifo
//   Small synchronous FIFO buffering OMEM read data ahead of the host writes.
//   DEPTH must be a power of two so the pointers wrap naturally.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, push_data write one entry (dropped if full)
//     pop             remove head entry (ignored if empty)
//     head            current head entry (undefined data when empty)
//     count           number of stored entries, 0..DEPTH
//     empty           no entries stored
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module omem_rb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/omem_readback_dma.sv
//------------------------------------------------------------------------------
// omem_readback_dma
//   Sweeps every OMEM bank after render completion and streams the words to
//   host memory as Wishbone single writes at BASE + linear word index.
//   Bank reads run ahead of the bus writes through a small FIFO; a credit rule
//   (stored + in-flight < depth) keeps the FIFO from ever overflowing.
//   Ports:
//     CLK_I, RST_I          clock, asynchronous active-low reset
//     START_I               begin sweep (accepted only when idle)
//     WORDS_I, BASE_I       words per bank / host base, sampled on START_I
//     OMBSEL_O, OMADR_O     OMEM read port (bank, address)
//     OMEM_I                read data, valid the cycle after the address
//     ADR_O, DAT_O          host write address / data
//     WE_O, STB_O, CYC_O    Wishbone master controls
//     ACK_I                 host acknowledge
//     BUSY_O, DONE_O        sweep in progress / last word acked (1 cycle)
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module omem_readback_dma
  import omem_readback_dma_pkg::*;
#(
  parameter int WB_WIDTH   = RB_WB_WIDTH,
  parameter int NUM_BANKS  = RB_MAX_CORES,
  parameter int BANK_BITS  = RB_MAX_CORE_BITS,
  parameter int FIFO_DEPTH = RB_FIFO_DEPTH
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 START_I,
  input  logic [WB_WIDTH-1:0]  WORDS_I,
  input  logic [WB_WIDTH-1:0]  BASE_I,
  output logic [BANK_BITS-1:0] OMBSEL_O,
  output logic [WB_WIDTH-1:0]  OMADR_O,
  input  logic [WB_WIDTH-1:0]  OMEM_I,
  output logic [WB_WIDTH-1:0]  ADR_O,
  output logic [WB_WIDTH-1:0]  DAT_O,
  output logic                 WE_O,
  output logic                 STB_O,
  output logic                 CYC_O,
  input  logic                 ACK_I,
  output logic                 BUSY_O,
  output logic                 DONE_O
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rb_state_t            state;
  rb_state_t            state_nx;
  logic [WB_WIDTH-1:0]  words_q;
  logic [WB_WIDTH-1:0]  base_q;
  logic [WB_WIDTH-1:0]  addr_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [WB_WIDTH-1:0]  idx_q;
  logic                 inflight_q;
  logic                 cyc_q;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [WB_WIDTH-1:0]  fifo_head;

  logic                 start_ok;
  logic                 credit_ok;
  logic                 issue;
  logic                 addr_last;
  logic                 last_rd;
  logic                 stb;
  logic                 pop;

  assign start_ok  = START_I && (state == RB_IDLE);
  // Count the in-flight read as already occupying a slot so that its data
  // always has room when it lands next cycle.
  assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state == RB_SWEEP) && credit_ok;
  assign addr_last = (addr_q == (words_q - WB_WIDTH'(1)));
  assign last_rd   = issue && addr_last && (bank_q == BANK_BITS'(NUM_BANKS - 1));

  assign stb       = !fifo_empty;
  assign pop       = stb && ACK_I;

  omem_rb_fifo #(
    .WIDTH (WB_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_I),
    .rst_n     (RST_I),
    .push      (inflight_q),
    .push_data (OMEM_I),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= RB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    BUSY_O   = 1'b0;
    DONE_O   = 1'b0;
    case (state)
      RB_IDLE: begin
        if (START_I) begin
          state_nx = (WORDS_I == '0) ? RB_FINISH : RB_SWEEP;
        end
      end
      RB_SWEEP: begin
        BUSY_O = 1'b1;
        if (last_rd) begin
          state_nx = RB_DRAIN;
        end
      end
      RB_DRAIN: begin
        BUSY_O = 1'b1;
        // An empty FIFO also means no strobe is outstanding.
        if (fifo_empty && !inflight_q) begin
          state_nx = RB_FINISH;
        end
      end
      RB_FINISH: begin
        BUSY_O   = 1'b1;
        DONE_O   = 1'b1;
        state_nx = RB_IDLE;
      end
      default: state_nx = RB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      words_q    <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      bank_q     <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      cyc_q      <= 1'b0;
    end else begin
      inflight_q <= issue;

      if (start_ok) begin
        words_q <= WORDS_I;
        base_q  <= BASE_I;
        addr_q  <= '0;
        bank_q  <= '0;
      end else if (issue) begin
        if (addr_last) begin
          addr_q <= '0;
          bank_q <= bank_q + BANK_BITS'(1);
        end else begin
          addr_q <= addr_q + WB_WIDTH'(1);
        end
      end

      if (start_ok) begin
        idx_q <= '0;
      end else if (pop) begin
        idx_q <= idx_q + WB_WIDTH'(1);
      end

      // Bus cycle stays claimed between strobes until the sweep finishes.
      if ((state == RB_DRAIN) && (state_nx == RB_FINISH)) begin
        cyc_q <= 1'b0;
      end else if (stb) begin
        cyc_q <= 1'b1;
      end
    end
  end

  // The read pointer registers are presented directly: the word is requested
  // in the cycle the issue decision is made and returns the following cycle.
  assign OMBSEL_O = bank_q;
  assign OMADR_O  = addr_q;

  assign ADR_O = base_q + idx_q;
  assign DAT_O = fifo_empty ? '0 : fifo_head;
  assign STB_O = stb;
  assign WE_O  = stb;
  assign CYC_O = cyc_q || stb;

endmodule

`default_nettype wire

// File: tb/tb_omem_readback_dma.sv
//------------------------------------------------------------------------------
// tb_omem_readback_dma
//   Directed bench for omem_readback_dma. Stimulus pushes the expected host
//   writes into a queue; an independent monitor pops and compares every acked
//   write. An OMEM model returns a recognisable word per (bank, address).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_omem_readback_dma;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        START_I;
  logic [31:0] WORDS_I;
  logic [31:0] BASE_I;
  logic [1:0]  OMBSEL_O;
  logic [31:0] OMADR_O;
  logic [31:0] OMEM_I;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;
  logic        BUSY_O;
  logic        DONE_O;

  omem_readback_dma dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .START_I  (START_I),
    .WORDS_I  (WORDS_I),
    .BASE_I   (BASE_I),
    .OMBSEL_O (OMBSEL_O),
    .OMADR_O  (OMADR_O),
    .OMEM_I   (OMEM_I),
    .ADR_O    (ADR_O),
    .DAT_O    (DAT_O),
    .WE_O     (WE_O),
    .STB_O    (STB_O),
    .CYC_O    (CYC_O),
    .ACK_I    (ACK_I),
    .BUSY_O   (BUSY_O),
    .DONE_O   (DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  // OMEM contents: 0xD0b0_0aaa style tag of bank and address.
  function automatic logic [31:0] mem_word(input logic [1:0] b, input logic [31:0] a);
    return 32'hD000_0000 | ({30'd0, b} << 20) | (a & 32'h000F_FFFF);
  endfunction

  // Synchronous read port: data valid the cycle after the address.
  always @(posedge CLK_I) OMEM_I <= mem_word(OMBSEL_O, OMADR_O);

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  int          stb_cyc = 0;
  int          acked = 0;
  logic [31:0] last_adr;
  logic [31:0] last_dat;
  int          ack_mode = 0;  // 0: low, 1: high, 2: random 50%

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ACK driver, updated just after each rising edge.
  always @(posedge CLK_I) begin
    #1;
    case (ack_mode)
      1:       ACK_I = 1'b1;
      2:       ACK_I = 1'($urandom_range(0, 1));
      default: ACK_I = 1'b0;
    endcase
  end

  // Monitor: every strobe that is acked this cycle is one host write.
  always @(negedge CLK_I) begin
    if (RST_I === 1'b1) begin
      if (DONE_O) done_cnt++;
      if (BUSY_O) busy_cyc++;
      if (STB_O)  stb_cyc++;
      if (STB_O && ACK_I) begin
        exp_t e;
        acked++;
        last_adr = ADR_O;
        last_dat = DAT_O;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h/%h expected=none", ADR_O, DAT_O);
        end else begin
          e = exp_q.pop_front();
          chk("wr_adr", ADR_O, e.adr);
          chk("wr_dat", DAT_O, e.dat);
          chk("wr_cyc_we", {30'd0, CYC_O, WE_O}, 32'd3);
        end
      end
    end
  end

  task automatic push_run(input logic [31:0] words, input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < int'(words); a++) begin
        exp_t e;
        e.adr = base + 32'(b) * words + 32'(a);
        e.dat = mem_word(2'(b), 32'(a));
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] w, input logic [31:0] b, input bit expect_run);
    if (expect_run) push_run(w, b);
    @(posedge CLK_I);
    #1;
    START_I = 1'b1;
    WORDS_I = w;
    BASE_I  = b;
    @(posedge CLK_I);
    #1;
    START_I = 1'b0;
    WORDS_I = 32'hFFFF_FFFF;
    BASE_I  = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK_I);
      #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_acked(input string name, input int target, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK_I);
      #1;
      if (acked >= target) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d expected=%0d acked", name, acked, target);
    end
  endtask

  initial begin
    int d0, b0, s0, a0;
    logic [31:0] adr0, dat0;
    bit stable;

    RST_I   = 1'b0;
    START_I = 1'b0;
    WORDS_I = '0;
    BASE_I  = '0;
    ACK_I   = 1'b0;
    repeat (3) @(negedge CLK_I);

    // Reset state
    chk("rst_omsel_omadr", {30'd0, OMBSEL_O} | OMADR_O, 32'd0);
    chk("rst_adr", ADR_O, 32'd0);
    chk("rst_dat", DAT_O, 32'd0);
    chk("rst_ctrl", {27'd0, WE_O, STB_O, CYC_O, BUSY_O, DONE_O}, 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // 1: WORDS=3, BASE=0x100, ACK tied high
    ack_mode = 1;
    d0 = done_cnt;
    do_start(32'd3, 32'h100, 1'b1);
    wait_done("t1", 200);
    chk("t1_last_adr", last_adr, 32'h0000_010B);
    chk("t1_last_dat", last_dat, 32'hD030_0002);
    chk("t1_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    @(negedge CLK_I);
    chk("t1_busy_after", {30'd0, BUSY_O, CYC_O}, 32'd0);
    repeat (3) @(negedge CLK_I);

    // 2: WORDS=0 finishes without any bus traffic
    d0 = done_cnt;
    b0 = busy_cyc;
    s0 = stb_cyc;
    do_start(32'd0, 32'h800, 1'b1);
    wait_done("t2", 20);
    repeat (3) @(negedge CLK_I);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t2_busy_cycles", 32'(busy_cyc - b0), 32'd1);
    chk("t2_stb_cycles", 32'(stb_cyc - s0), 32'd0);

    // 3: stall ACK for 20 cycles on word 1
    ack_mode = 1;
    a0 = acked;
    do_start(32'd3, 32'h200, 1'b1);
    wait_acked("t3_first", a0 + 1, 50);
    ack_mode = 0;
    @(negedge CLK_I);
    adr0   = ADR_O;
    dat0   = DAT_O;
    stable = 1'b1;
    repeat (20) begin
      @(negedge CLK_I);
      if (ADR_O !== adr0 || DAT_O !== dat0 || STB_O !== 1'b1) stable = 1'b0;
    end
    chk("t3_stall_adr", adr0, 32'h0000_0201);
    chk("t3_stall_dat", dat0, 32'hD000_0001);
    chk("t3_stall_stable", {31'd0, stable}, 32'd1);
    // Word 0 acked plus four buffered words: reads paused at linear word 5.
    chk("t3_read_ptr", {OMBSEL_O, OMADR_O[29:0]}, {2'd1, 30'd2});
    ack_mode = 1;
    wait_done("t3", 200);
    chk("t3_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t3_acked", 32'(acked - a0), 32'd12);
    repeat (3) @(negedge CLK_I);

    // 4: random ACK, WORDS=16
    ack_mode = 2;
    a0 = acked;
    do_start(32'd16, 32'h1000, 1'b1);
    wait_done("t4", 1500);
    chk("t4_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t4_acked", 32'(acked - a0), 32'd64);
    chk("t4_last_adr", last_adr, 32'h0000_103F);
    repeat (3) @(negedge CLK_I);

    // 5: START re-pulsed mid-sweep is ignored
    ack_mode = 2;
    a0 = acked;
    d0 = done_cnt;
    do_start(32'd5, 32'h0, 1'b1);
    repeat (6) @(negedge CLK_I);
    do_start(32'd7, 32'h5000, 1'b0);
    wait_done("t5", 600);
    repeat (3) @(negedge CLK_I);
    chk("t5_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t5_acked", 32'(acked - a0), 32'd20);
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 6: reset during DRAIN, then a clean sweep
    ack_mode = 1;
    a0 = acked;
    do_start(32'd4, 32'h300, 1'b1);
    wait_acked("t6_partial", a0 + 12, 100);
    ack_mode = 0;
    repeat (10) @(negedge CLK_I);
    chk("t6_pre_reset", {30'd0, BUSY_O, STB_O}, 32'd3);
    @(posedge CLK_I);
    #3;
    RST_I = 1'b0;
    #1;
    chk("t6_reset_drop", {28'd0, STB_O, CYC_O, BUSY_O, DONE_O}, 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (5) @(negedge CLK_I);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    ack_mode = 1;
    a0 = acked;
    do_start(32'd2, 32'h400, 1'b1);
    wait_done("t6", 200);
    chk("t6_queue_left", 32'(exp_q.size()), 32'd0);
    chk("t6_acked", 32'(acked - a0), 32'd8);
    repeat (3) @(negedge CLK_I);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
